// File: rtl/sig_rd_port_arbiter_if.sv
// sig_rd_port_arbiter_if: engine/memory-side bundle of the signature read-port arbiter (rd_wr_en 0=idle 1=read 2=write)
interface sig_rd_port_arbiter_if #(
  parameter int SIG_ADDR_W = 10,
  parameter int DATA_W = 80
);
  typedef struct packed {
    logic [1:0] rd_wr_en;
    logic [SIG_ADDR_W-1:0] addr;
  } sig_mem_if_t;
  logic [1:0] req_i;
  logic [1:0] done_i;
  logic [1:0] gnt_o;
  sig_mem_if_t [1:0] rq_rd_req_a_i;
  sig_mem_if_t [1:0] rq_rd_req_b_i;
  sig_mem_if_t sigmem_a_rd_req;
  sig_mem_if_t sigmem_b_rd_req;
  logic [DATA_W-1:0] sigmem_a_rd_data;
  logic [DATA_W-1:0] sigmem_b_rd_data;
  logic [DATA_W-1:0] rq_rd_data_a_o;
  logic [DATA_W-1:0] rq_rd_data_b_o;
  logic [1:0] rq_rd_vld_o;
  logic busy_o;
  logic err_o;
  modport master (
    output req_i, done_i, rq_rd_req_a_i, rq_rd_req_b_i, sigmem_a_rd_data, sigmem_b_rd_data,
    input gnt_o, sigmem_a_rd_req, sigmem_b_rd_req, rq_rd_data_a_o, rq_rd_data_b_o, rq_rd_vld_o, busy_o, err_o
  );
  modport slave (
    input req_i, done_i, rq_rd_req_a_i, rq_rd_req_b_i, sigmem_a_rd_data, sigmem_b_rd_data,
    output gnt_o, sigmem_a_rd_req, sigmem_b_rd_req, rq_rd_data_a_o, rq_rd_data_b_o, rq_rd_vld_o, busy_o, err_o
  );
endinterface

// File: rtl/sig_rd_port_arbiter.sv
// sig_rd_port_arbiter: grants exclusive ownership of signature-memory read ports A/B to one of two decode engines
module sig_rd_port_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  input logic zeroize,
  sig_rd_port_arbiter_if.slave bus
);
  localparam logic [1:0] RW_IDLE = 2'd0, RW_READ = 2'd1, RW_WRITE = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd0, S_OWN0 = 2'd1, S_OWN1 = 2'd2, S_DRAIN = 2'd3;
  localparam int CNT_W = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
  logic [1:0] r_state, w_nxt, r_gnt, w_vld_in, w_non_own, w_nonown_act, w_en_a, w_en_b;
  logic [1:0] r_vld [RD_LATENCY];
  logic r_rr_last, r_busy, r_err, w_own, w_idx, w_err, w_clr;
  logic [CNT_W-1:0] r_cnt;
  assign w_clr = reset | zeroize;
  assign w_own = r_state == S_OWN0 || r_state == S_OWN1;
  assign w_idx = r_state == S_OWN1;
  assign w_en_a = bus.rq_rd_req_a_i[w_idx].rd_wr_en;
  assign w_en_b = bus.rq_rd_req_b_i[w_idx].rd_wr_en;
  assign bus.sigmem_a_rd_req = (w_own && w_en_a != RW_WRITE) ? bus.rq_rd_req_a_i[w_idx] : '0;
  assign bus.sigmem_b_rd_req = (w_own && w_en_b != RW_WRITE) ? bus.rq_rd_req_b_i[w_idx] : '0;
  assign w_non_own = ~{w_own & w_idx, w_own & ~w_idx};
  for (genvar g = 0; g < 2; g++) begin : g_nonown
    assign w_nonown_act[g] = w_non_own[g] &&
      (bus.rq_rd_req_a_i[g].rd_wr_en != RW_IDLE || bus.rq_rd_req_b_i[g].rd_wr_en != RW_IDLE);
  end
  assign w_err = |w_nonown_act || (w_own && (w_en_a == RW_WRITE || w_en_b == RW_WRITE || w_en_a != w_en_b));
  assign w_vld_in = (w_own && w_en_a == RW_READ) ? {w_idx, ~w_idx} : 2'b00;
  assign bus.gnt_o = r_gnt;
  assign bus.busy_o = r_busy;
  assign bus.err_o = r_err;
  assign bus.rq_rd_vld_o = r_vld[RD_LATENCY-1];
  assign bus.rq_rd_data_a_o = bus.sigmem_a_rd_data;
  assign bus.rq_rd_data_b_o = bus.sigmem_b_rd_data;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: w_nxt = ~|bus.req_i ? S_IDLE :
                      bus.req_i == 2'b11 ? (r_rr_last ? S_OWN0 : S_OWN1) :
                      bus.req_i[0] ? S_OWN0 : S_OWN1;
      S_OWN0: w_nxt = (bus.done_i[0] || !bus.req_i[0]) ? S_DRAIN : S_OWN0;
      S_OWN1: w_nxt = (bus.done_i[1] || !bus.req_i[1]) ? S_DRAIN : S_OWN1;
      default: w_nxt = r_cnt == '0 ? S_IDLE : S_DRAIN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= S_IDLE;
      r_gnt <= '0;
      r_busy <= 1'b0;
      r_err <= 1'b0;
      r_rr_last <= 1'b1;
      r_cnt <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_vld[i] <= '0;
    end else begin
      r_state <= w_nxt;
      r_gnt <= {w_nxt == S_OWN1, w_nxt == S_OWN0};
      r_busy <= w_nxt != S_IDLE;
      r_err <= r_err | w_err;
      if (r_state == S_IDLE && w_nxt != S_IDLE) r_rr_last <= w_nxt == S_OWN1;
      r_cnt <= r_state != S_DRAIN ? CNT_W'(RD_LATENCY - 1) : r_cnt - 1'b1;
      r_vld[0] <= w_vld_in;
      for (int i = 1; i < RD_LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end
endmodule

// File: tb/tb_sig_rd_port_arbiter.sv
// tb_sig_rd_port_arbiter: directed checks of grant, forwarding, valid tagging, errors and zeroize
module tb_sig_rd_port_arbiter;
  logic clk = 1'b0, reset = 1'b1, zeroize = 1'b0;
  int n_chk = 0, n_fail = 0, n_vld = 0;
  sig_rd_port_arbiter_if #(.SIG_ADDR_W(10), .DATA_W(80)) bus ();
  sig_rd_port_arbiter #(.RD_LATENCY(1)) dut (.clk(clk), .reset(reset), .zeroize(zeroize), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_rq(input int x, input logic [1:0] ea, input logic [9:0] aa, input logic [1:0] eb, input logic [9:0] ab);
    bus.rq_rd_req_a_i[x] = {ea, aa};
    bus.rq_rd_req_b_i[x] = {eb, ab};
  endtask
  task automatic idle_rq();
    bus.rq_rd_req_a_i = '0;
    bus.rq_rd_req_b_i = '0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.req_i = '0;
    bus.done_i = '0;
    idle_rq();
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    bus.sigmem_a_rd_data = '0;
    bus.sigmem_b_rd_data = '0;
    do_reset();
    chk("rst_gnt", bus.gnt_o, 2'b00);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    chk("rst_vld", bus.rq_rd_vld_o, 2'b00);
    chk("rst_mem_a", bus.sigmem_a_rd_req, 12'h000);
    bus.req_i = 2'b01;
    tick();
    chk("grant0", bus.gnt_o, 2'b01);
    chk("busy_own", bus.busy_o, 1'b1);
    set_rq(0, 2'd1, 10'd0, 2'd1, 10'd1);
    bus.sigmem_a_rd_data = 80'h1234_5678;
    bus.sigmem_b_rd_data = 80'hABCD;
    #1;
    chk("fwd_a", bus.sigmem_a_rd_req, 12'h400);
    chk("fwd_b", bus.sigmem_b_rd_req, 12'h401);
    chk("data_a", bus.rq_rd_data_a_o, 80'h1234_5678);
    chk("data_b", bus.rq_rd_data_b_o, 80'hABCD);
    chk("vld_early", bus.rq_rd_vld_o, 2'b00);
    tick();
    chk("vld0", bus.rq_rd_vld_o, 2'b01);
    idle_rq();
    tick();
    chk("vld0_end", bus.rq_rd_vld_o, 2'b00);
    bus.done_i = 2'b01;
    bus.req_i = 2'b00;
    tick();
    bus.done_i = 2'b00;
    chk("drain_gnt", bus.gnt_o, 2'b00);
    chk("drain_busy", bus.busy_o, 1'b1);
    tick();
    chk("idle_busy", bus.busy_o, 1'b0);
    chk("no_err", bus.err_o, 1'b0);
    do_reset();
    bus.req_i = 2'b11;
    tick();
    chk("tie_first", bus.gnt_o, 2'b01);
    bus.done_i = 2'b01;
    tick();
    bus.done_i = 2'b00;
    chk("tie_drain_gnt", bus.gnt_o, 2'b00);
    chk("tie_drain_busy", bus.busy_o, 1'b1);
    tick();
    chk("tie_idle_gnt", bus.gnt_o, 2'b00);
    chk("tie_idle_busy", bus.busy_o, 1'b0);
    tick();
    chk("tie_second", bus.gnt_o, 2'b10);
    bus.done_i = 2'b01;
    tick();
    bus.done_i = 2'b00;
    chk("done_nonowner", bus.gnt_o, 2'b10);
    bus.req_i = 2'b00;
    tick();
    tick();
    chk("err_clean", bus.err_o, 1'b0);
    bus.req_i = 2'b01;
    tick();
    chk("rr_single", bus.gnt_o, 2'b01);
    set_rq(0, 2'd1, 10'd3, 2'd1, 10'd3);
    set_rq(1, 2'd1, 10'd5, 2'd1, 10'd5);
    #1;
    chk("gate_a", bus.sigmem_a_rd_req, 12'h403);
    chk("gate_b", bus.sigmem_b_rd_req, 12'h403);
    chk("err_pre", bus.err_o, 1'b0);
    tick();
    chk("err_set", bus.err_o, 1'b1);
    chk("gate_vld", bus.rq_rd_vld_o, 2'b01);
    idle_rq();
    tick();
    chk("err_sticky", bus.err_o, 1'b1);
    do_reset();
    bus.req_i = 2'b01;
    tick();
    set_rq(0, 2'd2, 10'd7, 2'd2, 10'd7);
    #1;
    chk("wr_block_a", bus.sigmem_a_rd_req, 12'h000);
    chk("wr_block_b", bus.sigmem_b_rd_req, 12'h000);
    tick();
    chk("wr_err", bus.err_o, 1'b1);
    chk("wr_vld", bus.rq_rd_vld_o, 2'b00);
    do_reset();
    bus.req_i = 2'b01;
    tick();
    set_rq(0, 2'd1, 10'd1, 2'd2, 10'd1);
    tick();
    chk("ab_mismatch_err", bus.err_o, 1'b1);
    do_reset();
    bus.req_i = 2'b01;
    tick();
    set_rq(0, 2'd1, 10'd9, 2'd1, 10'd9);
    bus.done_i = 2'b01;
    bus.req_i = 2'b00;
    #1;
    chk("done_rd_fwd", bus.sigmem_a_rd_req, 12'h409);
    tick();
    idle_rq();
    bus.done_i = 2'b00;
    chk("done_rd_vld", bus.rq_rd_vld_o, 2'b01);
    chk("done_rd_gnt", bus.gnt_o, 2'b00);
    chk("done_rd_busy", bus.busy_o, 1'b1);
    tick();
    chk("done_rd_vld_off", bus.rq_rd_vld_o, 2'b00);
    chk("done_rd_idle", bus.busy_o, 1'b0);
    chk("done_rd_err", bus.err_o, 1'b0);
    bus.req_i = 2'b01;
    tick();
    for (int i = 0; i < 160; i++) begin
      set_rq(0, 2'd1, 10'(i), 2'd1, 10'(i));
      tick();
      if (bus.rq_rd_vld_o == 2'b01) n_vld++;
    end
    chk("z_vld_count", 32'(n_vld), 32'd160);
    set_rq(0, 2'd1, 10'd160, 2'd1, 10'd160);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("z_gnt", bus.gnt_o, 2'b00);
    chk("z_mem_a", bus.sigmem_a_rd_req, 12'h000);
    chk("z_mem_b", bus.sigmem_b_rd_req, 12'h000);
    chk("z_vld", bus.rq_rd_vld_o, 2'b00);
    chk("z_busy", bus.busy_o, 1'b0);
    chk("z_err", bus.err_o, 1'b0);
    do_reset();
    bus.req_i = 2'b10;
    tick();
    chk("drop_gnt", bus.gnt_o, 2'b10);
    bus.req_i = 2'b00;
    tick();
    chk("drop_drain_gnt", bus.gnt_o, 2'b00);
    chk("drop_drain_busy", bus.busy_o, 1'b1);
    tick();
    chk("drop_idle", bus.busy_o, 1'b0);
    chk("drop_err", bus.err_o, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
